vram_slot_scheduler: RTL

Time-slot scheduler for the single-port video RAM. Uses the raster position from the sync generator to reserve one RAM cycle per tile for the display fetch, and shares every other cycle between two host requesters (CPU, blitter) by round-robin. Sits between the sync generator, the tile/pixel pipeline and the VRAM macro (synchronous read, 1-cycle latency).

---
 rtl/vram_pkg.sv | 16 +
 rtl/vram_rr_arb.sv | 45 ++++
 rtl/vram_slot_scheduler.sv | 135 +++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// Shared types and default widths for the VRAM slot scheduler.
// owner_t tags every RAM access so the read-return stage knows where
// the data belongs.
package vram_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_H0   = 2'd2,
        OWN_H1   = 2'd3
    } owner_t;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/vram_rr_arb.sv
// Two-way round-robin arbiter for the host side of the VRAM port.
//   clk, reset_n : clock, asynchronous active-low reset
//   block        : video owns this cycle, no host may win
//   req0/req1    : host requests, held until granted
//   pick0/pick1  : combinational winner of the current cycle
//   gnt0/gnt1    : registered grant pulses (pick delayed one cycle)
// A host whose grant is visible this cycle is masked, so a request that
// is still held while the host reacts to its grant is not granted twice.
module vram_rr_arb (
    input  logic clk,
    input  logic reset_n,
    input  logic block,
    input  logic req0,
    input  logic req1,
    output logic pick0,
    output logic pick1,
    output logic gnt0,
    output logic gnt1
);

    logic last1;   // 1: h1 was granted most recently, so h0 has priority
    logic elig0;
    logic elig1;

    assign elig0 = req0 & ~gnt0;
    assign elig1 = req1 & ~gnt1;
    assign pick0 = ~block & elig0 & (~elig1 | last1);
    assign pick1 = ~block & elig1 & (~elig0 | ~last1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            last1 <= 1'b1;
        end else begin
            gnt0 <= pick0;
            gnt1 <= pick1;
            if (pick0)
                last1 <= 1'b0;
            else if (pick1)
                last1 <= 1'b1;
        end
    end

endmodule

// File: rtl/vram_slot_scheduler.sv
// Time-slot scheduler for the single-port VRAM.
// Reserves the first pixel of every visible tile for the tile-map fetch
// and shares all other cycles between two hosts by round-robin.
//   clk, reset_n              : clock, asynchronous active-low reset
//   hpos, vpos                : raster position from the sync generator
//   vram_addr/we/wdata        : registered RAM command
//   vram_rdata                : RAM read data, one cycle after the address
//   vid_data, vid_valid       : fetched tile code and its update pulse
//   hN_req/we/addr/wdata      : host N request
//   hN_gnt                    : host N grant pulse
//   hN_rdata, hN_rvalid       : host N read data and its valid pulse
// Slot-to-vid_valid latency is a fixed 3 cycles; host rvalid follows the
// grant pulse by 2 cycles.
module vram_slot_scheduler
    import vram_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int H_DISPLAY   = 640,
    parameter int V_DISPLAY   = 480,
    parameter int TILE_W_LOG2 = 3,
    parameter int TILE_H_LOG2 = 3,
    parameter int VID_BASE    = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       hpos,
    input  logic [15:0]       vpos,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_we,
    output logic [DATA_W-1:0] vram_wdata,
    input  logic [DATA_W-1:0] vram_rdata,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    input  logic              h0_req,
    input  logic              h0_we,
    input  logic [ADDR_W-1:0] h0_addr,
    input  logic [DATA_W-1:0] h0_wdata,
    output logic              h0_gnt,
    output logic [DATA_W-1:0] h0_rdata,
    output logic              h0_rvalid,
    input  logic              h1_req,
    input  logic              h1_we,
    input  logic [ADDR_W-1:0] h1_addr,
    input  logic [DATA_W-1:0] h1_wdata,
    output logic              h1_gnt,
    output logic [DATA_W-1:0] h1_rdata,
    output logic              h1_rvalid
);

    localparam logic [15:0] H_LIMIT       = 16'(H_DISPLAY);
    localparam logic [15:0] V_LIMIT       = 16'(V_DISPLAY);
    localparam logic [31:0] TILES_PER_ROW = 32'(H_DISPLAY >> TILE_W_LOG2);

    logic              vid_slot_p0;
    logic [15:0]       tile_col;
    logic [15:0]       tile_row;
    logic [ADDR_W-1:0] fetch_addr_p0;
    logic              pick0;
    logic              pick1;
    owner_t            owner_p1;
    owner_t            owner_p2;

    assign vid_slot_p0 = (vpos < V_LIMIT) && (hpos < H_LIMIT) &&
                         (hpos[TILE_W_LOG2-1:0] == '0);
    assign tile_col    = hpos >> TILE_W_LOG2;
    assign tile_row    = vpos >> TILE_H_LOG2;
    assign fetch_addr_p0 = ADDR_W'(VID_BASE)
                         + ADDR_W'({16'd0, tile_row} * TILES_PER_ROW)
                         + ADDR_W'(tile_col);

    vram_rr_arb u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .block   (vid_slot_p0),
        .req0    (h0_req),
        .req1    (h1_req),
        .pick0   (pick0),
        .pick1   (pick1),
        .gnt0    (h0_gnt),
        .gnt1    (h1_gnt)
    );

    // ---- stage 0 -> 1: decision registered onto the RAM port ----
    // Host writes are tagged NONE: they return nothing, so they must not
    // produce an rvalid pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vram_addr  <= '0;
            vram_we    <= 1'b0;
            vram_wdata <= '0;
            owner_p1   <= OWN_NONE;
        end else if (vid_slot_p0) begin
            vram_addr <= fetch_addr_p0;
            vram_we   <= 1'b0;
            owner_p1  <= OWN_VID;
        end else if (pick0) begin
            vram_addr  <= h0_addr;
            vram_we    <= h0_we;
            vram_wdata <= h0_wdata;
            owner_p1   <= h0_we ? OWN_NONE : OWN_H0;
        end else if (pick1) begin
            vram_addr  <= h1_addr;
            vram_we    <= h1_we;
            vram_wdata <= h1_wdata;
            owner_p1   <= h1_we ? OWN_NONE : OWN_H1;
        end else begin
            vram_we  <= 1'b0;
            owner_p1 <= OWN_NONE;
        end
    end

    // ---- stage 1 -> 2: tag waits for the RAM's read latency ----
    // ---- stage 2 -> 3: read data steered to its owner ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_p2  <= OWN_NONE;
            vid_data  <= '0;
            vid_valid <= 1'b0;
            h0_rdata  <= '0;
            h0_rvalid <= 1'b0;
            h1_rdata  <= '0;
            h1_rvalid <= 1'b0;
        end else begin
            owner_p2  <= owner_p1;
            vid_valid <= (owner_p2 == OWN_VID);
            h0_rvalid <= (owner_p2 == OWN_H0);
            h1_rvalid <= (owner_p2 == OWN_H1);
            if (owner_p2 == OWN_VID) vid_data <= vram_rdata;
            if (owner_p2 == OWN_H0)  h0_rdata <= vram_rdata;
            if (owner_p2 == OWN_H1)  h1_rdata <= vram_rdata;
        end
    end

endmodule
